// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  // lsb_type encodings: [3]=store, [2]=unsigned, [1:0]=size
  localparam logic [3:0] LB  = 4'b0000;
  localparam logic [3:0] LH  = 4'b0001;
  localparam logic [3:0] LW  = 4'b0010;
  localparam logic [3:0] LBU = 4'b0100;
  localparam logic [3:0] LHU = 4'b0101;
  localparam logic [3:0] SB  = 4'b1000;
  localparam logic [3:0] SH  = 4'b1001;
  localparam logic [3:0] SW  = 4'b1010;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_FETCH} state_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic [3:0][7:0] wdata;
    logic [1:0]      sz;
    logic            uns;
    logic [2:0]      nb;
    logic            io;
  } req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Sign/zero extension of an assembled little-endian load value.
module load_ext (
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] val
);

  always_comb begin
    case (size)
      2'd0:    val = {{24{raw[7] & ~uns}}, raw[7:0]};
      2'd1:    val = {{16{raw[15] & ~uns}}, raw[15:0]};
      default: val = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Serialises LSB loads/stores and instruction fetches onto a byte-wide RAM/IO bus.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        ls_enable,
  input  logic [31:0] addr,
  input  logic [31:0] store_val,
  input  logic [3:0]  lsb_type,
  output logic        ls_finished,
  output logic [31:0] load_val,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_finished,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t          state, state_nxt;
  req_t            req;
  logic [2:0]      cnt;
  logic [3:0][7:0] raw, raw_nxt;
  logic            flush_pend;
  logic            idle_ok, acc_ls, acc_if, stall, wr_cyc, rd_last, st_last;
  logic [31:0]     ext_val, a_nxt;
  logic [1:0]      lane;

  assign idle_ok = (state == ST_IDLE) && !clear && !ls_finished && !if_finished;
  assign acc_ls  = idle_ok && ls_enable;
  assign acc_if  = idle_ok && !ls_enable && if_enable;
  assign stall   = req.io && io_buffer_full;
  assign rd_last = (cnt == req.nb);
  assign st_last = (cnt == req.nb - 3'd1);
  assign a_nxt   = req.addr + 32'(cnt) + 32'd1;
  // cnt runs one ahead of the byte arriving on mem_din
  assign lane    = 2'(cnt - 3'd1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= ST_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (acc_ls)      state_nxt = lsb_type[3] ? ST_STORE : ST_LOAD;
        else if (acc_if) state_nxt = ST_FETCH;
      end
      ST_LOAD, ST_FETCH: if (clear || rd_last) state_nxt = ST_IDLE;
      ST_STORE:          if (!stall && st_last) state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_cyc  = (state == ST_STORE) && !stall;
    mem_wr  = rdy_in && wr_cyc;
    raw_nxt = raw;
    if (cnt != 3'd0) raw_nxt[lane] = mem_din;
  end

  load_ext u_ext (
    .raw  (raw_nxt),
    .size (req.sz),
    .uns  (req.uns),
    .val  (ext_val)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      req         <= '0;
      cnt         <= '0;
      raw         <= '0;
      flush_pend  <= 1'b0;
      mem_a       <= '0;
      mem_dout    <= '0;
      ls_finished <= 1'b0;
      if_finished <= 1'b0;
      load_val    <= '0;
      if_data     <= '0;
    end else if (rdy_in) begin
      ls_finished <= 1'b0;
      if_finished <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt        <= '0;
          flush_pend <= 1'b0;
          if (acc_ls) begin
            req      <= '{addr: addr, wdata: store_val, sz: lsb_type[1:0], uns: lsb_type[2],
                          nb: size_bytes(lsb_type[1:0]), io: (addr >= IO_BASE)};
            mem_a    <= addr;
            mem_dout <= store_val[7:0];
          end else if (acc_if) begin
            req   <= '{addr: if_addr, wdata: '0, sz: 2'd2, uns: 1'b0, nb: 3'd4, io: 1'b0};
            mem_a <= if_addr;
          end
        end
        ST_LOAD, ST_FETCH: begin
          if (!clear) begin
            cnt <= cnt + 3'd1;
            raw <= raw_nxt;
            if (cnt + 3'd1 < req.nb) mem_a <= a_nxt;
            if (rd_last) begin
              if (state == ST_LOAD) begin
                ls_finished <= 1'b1;
                load_val    <= ext_val;
              end else begin
                if_finished <= 1'b1;
                if_data     <= raw_nxt;
              end
            end
          end
        end
        ST_STORE: begin
          // a flushed store still drains every byte; only its completion is hidden
          if (clear) flush_pend <= 1'b1;
          if (!stall) begin
            cnt <= cnt + 3'd1;
            if (st_last) begin
              ls_finished <= !(flush_pend || clear);
              if (!(flush_pend || clear)) load_val <= '0;
            end else begin
              mem_a    <= a_nxt;
              mem_dout <= req.wdata[2'(cnt + 3'd1)];
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
